// File: rtl/pixel_color_out.sv
// Output colour stage: maps a qualified 1-bit pixel stream onto a
// programmable foreground/background colour pair, with normal, invert,
// blink and blank display modes. One registered output stage.
module pixel_color_out #(
    parameter int unsigned          COLOR_W      = 8,
    parameter logic [COLOR_W-1:0]   FG_RESET     = COLOR_W'('hFF),
    parameter logic [COLOR_W-1:0]   BG_RESET     = COLOR_W'('h00),
    parameter int unsigned          BLINK_PERIOD = 50,
    parameter int unsigned          BLINK_W      = 6
) (
    input  logic               clk_u,
    input  logic               rst_n_u,
    input  logic               pixel_in,
    input  logic               pixel_valid,
    input  logic [1:0]         mode,
    input  logic               cfg_load,
    input  logic [COLOR_W-1:0] fg_color_in,
    input  logic [COLOR_W-1:0] bg_color_in,
    output logic [COLOR_W-1:0] color_out,
    output logic               color_valid,
    output logic               blink_phase
);

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_INVERT = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_BLANK  = 2'b11
    } mode_e;

    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);

    logic [COLOR_W-1:0] fg_q, fg_d;
    logic [COLOR_W-1:0] bg_q, bg_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [COLOR_W-1:0] color_out_q, color_out_d;
    logic               color_valid_q, color_valid_d;
    logic [COLOR_W-1:0] color_sel;
    mode_e              mode_cur;

    assign mode_cur = mode_e'(mode);

    // Colour registers: a load strobe takes effect from the next cycle, so a
    // pixel presented alongside the strobe still sees the old pair.
    always_comb begin
        fg_d = fg_q;
        bg_d = bg_q;
        if (cfg_load) begin
            fg_d = fg_color_in;
            bg_d = bg_color_in;
        end
    end

    // Free-running blink timer: phase flips once per BLINK_PERIOD cycles.
    always_comb begin
        blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Colour select from the current mode and the registered blink phase.
    always_comb begin
        color_sel = bg_q;
        unique case (mode_cur)
            MODE_NORMAL: color_sel = pixel_in ? fg_q : bg_q;
            MODE_INVERT: color_sel = pixel_in ? bg_q : fg_q;
            MODE_BLINK:  color_sel = (!blink_phase_q && pixel_in) ? fg_q : bg_q;
            MODE_BLANK:  color_sel = bg_q;
            default:     color_sel = bg_q;
        endcase
    end

    // Output stage: capture on valid pixels, hold the last colour otherwise.
    always_comb begin
        color_valid_d = pixel_valid;
        color_out_d   = pixel_valid ? color_sel : color_out_q;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_u or negedge rst_n_u) begin
        if (!rst_n_u) begin
            fg_q          <= FG_RESET;
            bg_q          <= BG_RESET;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            color_out_q   <= '0;
            color_valid_q <= 1'b0;
        end else begin
            fg_q          <= fg_d;
            bg_q          <= bg_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            color_out_q   <= color_out_d;
            color_valid_q <= color_valid_d;
        end
    end

    assign color_out   = color_out_q;
    assign color_valid = color_valid_q;
    assign blink_phase = blink_phase_q;

endmodule
